fifo_access_sched: RTL
======================

# fifo_access_sched

Access scheduler that owns the control port of the shared 8-bit `fifo` instance. It arbitrates up to `NUM_WR` producers round-robin onto the FIFO write side and one consumer onto the read side. It never asserts write and read in the same cycle, because the FIFO ignores simultaneous write and read. It keeps its own occupancy count so that its registered commands can never overflow or underflow the FIFO, and it cross-checks that count against the FIFO's `empty`/`full` flags.

## Interface

Parameters:
- `NUM_WR`, default 4: number of write requesters (2..8).
- `FIFO_WIDTH`, default 8: data width; must match the FIFO.
- `FIFO_DEPTH`, default 64: FIFO capacity; must match the FIFO.

Ports:
- `clk`  in  1: single clock; everything is on the rising edge.
- `rstN`  in  1: synchronous reset, active-low.
- `wr_req`  in  `NUM_WR`: per-producer write request, level.
- `wr_data`  in  `NUM_WR*FIFO_WIDTH`: producer data; slice i is `[i*FIFO_WIDTH +: FIFO_WIDTH]`.
- `wr_gnt`  out  `NUM_WR`: one-hot, one-cycle pulse; the write was committed.
- `rd_req`  in  1: consumer read request, level.
- `rd_gnt`  out  1: one-cycle pulse; the read was committed.
- `rd_valid`  out  1: one-cycle pulse; `rd_data` is valid.
- `rd_data`  out  `FIFO_WIDTH`: read data.
- `fifo_wr_en`  out  1: drives the FIFO `wr_en`.
- `fifo_rd_en`  out  1: drives the FIFO `rd_en`.
- `fifo_data_in`  out  `FIFO_WIDTH`: drives the FIFO `data_in`.
- `fifo_data_out`  in  `FIFO_WIDTH`: from the FIFO `data_out`.
- `fifo_empty`, `fifo_full`  in  1: FIFO status flags.
- `count`  out  `$clog2(FIFO_DEPTH+1)`: committed occupancy.
- `err`  out  1: sticky flag; count and FIFO flags disagree.

## Operation

- **Eligibility in cycle t:**
  - Writer i is eligible when `wr_req[i]=1`, `wr_gnt[i]=0`, and `count < FIFO_DEPTH`.
  - The reader is eligible when `rd_req=1`, `rd_gnt=0`, and `count > 0`.
  - A granted requester is masked in its grant cycle, so it must drop its request or change its data the following cycle.
- **Writer selection:** round-robin, starting at `last_wr+1` (mod `NUM_WR`). `last_wr` updates only when a write is issued.
- **Read/write conflict:** if both a writer and the reader are eligible, the `rd_pri` bit decides.
  - `rd_pri=1`: the read wins. `rd_pri=0`: the write wins.
  - `rd_pri` toggles after every conflict cycle and is unchanged otherwise.
- **Issue:** at most one operation per cycle. At the edge ending cycle t:
  - Write: `fifo_wr_en<=1`, `fifo_data_in<=wr_data[i]`, `wr_gnt[i]<=1`, `count<=count+1`.
  - Read: `fifo_rd_en<=1`, `rd_gnt<=1`, `count<=count-1`.
  - Nothing issued: all command and grant outputs go to 0, and `fifo_data_in` holds its value.
- **Read data:** `rd_valid` is `fifo_rd_en` delayed by one cycle. In that cycle `rd_data` is combinationally `fifo_data_out`.
- **Cross-check:** `cnt_d` is `count` delayed by one cycle.
  - `err` sets when `(cnt_d==0)!=fifo_empty` or `(cnt_d==FIFO_DEPTH)!=fifo_full`.
  - The check is suppressed in the first cycle after reset.
  - Once set, `err` clears only on reset.
- **Reset (`rstN=0` at an edge):** `count`, `cnt_d`, `err`, `rd_pri`, `fifo_wr_en`, `fifo_rd_en`, `fifo_data_in`, `wr_gnt`, `rd_gnt` and `rd_valid` all become 0, and `last_wr=NUM_WR-1`.
  - A reset mid-operation drops every pending and in-flight operation without completing it.
  - The FIFO is reset from the same `rstN`.

## Timing

- **Write latency:** request sampled in cycle t; `fifo_wr_en`/`wr_gnt` high in t+1; data stored in the FIFO at the edge ending t+1.
- **Read latency:** request sampled in t; `fifo_rd_en`/`rd_gnt` high in t+1; `rd_valid` and `rd_data` in t+2.
- **Throughput:** one operation per cycle. A single requester holding its request continuously is served at most every other cycle.
- **Full boundary:** at `count=FIFO_DEPTH` no write is issued. A read issued in that cycle makes writes eligible the next cycle.
- **Empty boundary:** at `count=0` no read is issued. A write and a read are never issued together, so a write at `count=0` cannot be overtaken.
- **Count width:** `count` is 7 bits for the default depth, so it spans the full range 0..64 without wrap. It never exceeds `FIFO_DEPTH` and never underflows.

## Test plan

- **Reset state:** hold `rstN=0` for 2 cycles with all requests high. Every output reads 0, then writer 0 is granted first.
- **Round-robin:** assert `wr_req=4'b1111` continuously with distinct data per writer. `wr_gnt` sequence is 0,1,2,3,0,..., and `count` increments every cycle.
- **Fill to full:** writer 0 only, 64 writes. `count=64`, `fifo_full=1`, no 65th `wr_gnt`, `err=0`.
- **Drain:** from full, `rd_req=1` continuously. `rd_gnt` pulses every other cycle, `rd_data` returns the 64 words in write order with `rd_valid` at t+2, and at `count=0` reads stop with `fifo_empty=1`.
- **Conflict alternation:** `count=5`, `wr_req[2]=1` and `rd_req=1` held. Grants alternate write, read, write, ..., `fifo_wr_en & fifo_rd_en` is never 1, and `count` stays within 5..6.
- **Mid-operation reset, then cross-check:**
  - Pull `rstN` low during a burst at `count=10`. Everything returns to its reset value, and the next write is stored at FIFO address 0.
  - Force `fifo_full=1` at `count=3`. `err` sets and stays set until reset.

Source files
------------

// File: rtl/fifo_access_sched.sv
// -----------------------------------------------------------------------------
// fifo_access_sched
// Owns the control port of a shared FIFO. Arbitrates NUM_WR producers
// round-robin onto the write side and a single consumer onto the read side,
// issuing at most one registered command per cycle (never write and read
// together). Tracks committed occupancy so commands cannot overflow or
// underflow the FIFO, and cross-checks that count against the FIFO flags.
//
// Ports
//   clk, rstN      : clock, synchronous active-low reset
//   wr_req/wr_data : per-producer write request (level) and data slices
//   wr_gnt         : one-hot pulse, write committed
//   rd_req/rd_gnt  : consumer read request (level) / read committed pulse
//   rd_valid/rd_data : read data returned two cycles after the request
//   fifo_*         : FIFO command, data and status connections
//   count          : committed occupancy, 0..FIFO_DEPTH
//   err            : sticky, occupancy and FIFO flags disagree
// -----------------------------------------------------------------------------
module fifo_access_sched #(
   parameter int unsigned NUM_WR     = 4,
   parameter int unsigned FIFO_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 64
) (
   input  logic                             clk,
   input  logic                             rstN,
   input  logic [NUM_WR-1:0]                wr_req,
   input  logic [NUM_WR*FIFO_WIDTH-1:0]     wr_data,
   output logic [NUM_WR-1:0]                wr_gnt,
   input  logic                             rd_req,
   output logic                             rd_gnt,
   output logic                             rd_valid,
   output logic [FIFO_WIDTH-1:0]            rd_data,
   output logic                             fifo_wr_en,
   output logic                             fifo_rd_en,
   output logic [FIFO_WIDTH-1:0]            fifo_data_in,
   input  logic [FIFO_WIDTH-1:0]            fifo_data_out,
   input  logic                             fifo_empty,
   input  logic                             fifo_full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
   output logic                             err
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

   // Registered state
   logic [NUM_WR-1:0]     wr_gnt_q,       wr_gnt_d;
   logic                  rd_gnt_q,       rd_gnt_d;
   logic                  rd_valid_q,     rd_valid_d;
   logic                  fifo_wr_en_q,   fifo_wr_en_d;
   logic                  fifo_rd_en_q,   fifo_rd_en_d;
   logic [FIFO_WIDTH-1:0] fifo_data_in_q, fifo_data_in_d;
   logic [CNT_W-1:0]      count_q,        count_d;
   logic [CNT_W-1:0]      cnt_dly_q,      cnt_dly_d;
   logic                  err_q,          err_d;
   logic                  rd_pri_q,       rd_pri_d;
   logic [IDX_W-1:0]      last_wr_q,      last_wr_d;
   logic                  chk_en_q,       chk_en_d;

   // Arbitration signals
   logic [NUM_WR-1:0]     wr_elig;
   logic                  wr_any;
   logic                  rd_elig;
   logic                  do_wr;
   logic                  do_rd;
   logic [IDX_W-1:0]      wr_sel;
   logic [IDX_W-1:0]      rr_idx;
   logic                  cnt_room;
   logic                  cnt_avail;
   logic                  flag_mismatch;

   assign cnt_room  = (count_q < CNT_W'(FIFO_DEPTH));
   assign cnt_avail = (count_q != '0);

   // Eligibility and round-robin writer selection
   always_comb begin : arb_p
      wr_elig = '0;
      wr_any  = 1'b0;
      wr_sel  = last_wr_q;
      rr_idx  = '0;
      for (int k = 0; k < int'(NUM_WR); k++) begin
         wr_elig[k] = wr_req[k] & ~wr_gnt_q[k] & cnt_room;
      end
      // Scan farthest offset first so the nearest eligible writer after last_wr wins
      for (int off = int'(NUM_WR); off > 0; off--) begin
         rr_idx = IDX_W'((int'(last_wr_q) + off) % int'(NUM_WR));
         if (wr_elig[rr_idx]) begin
            wr_any = 1'b1;
            wr_sel = rr_idx;
         end
      end
      rd_elig = rd_req & ~rd_gnt_q & cnt_avail;
   end

   // Read/write conflict resolution; rd_pri flips only on conflict cycles
   always_comb begin : conflict_p
      do_wr    = wr_any;
      do_rd    = rd_elig;
      rd_pri_d = rd_pri_q;
      if (wr_any && rd_elig) begin
         if (rd_pri_q) begin
            do_wr = 1'b0;
         end else begin
            do_rd = 1'b0;
         end
         rd_pri_d = ~rd_pri_q;
      end
   end

   // Command issue, occupancy tracking and flag cross-check
   always_comb begin : next_p
      wr_gnt_d       = '0;
      rd_gnt_d       = 1'b0;
      fifo_wr_en_d   = 1'b0;
      fifo_rd_en_d   = 1'b0;
      fifo_data_in_d = fifo_data_in_q;
      count_d        = count_q;
      last_wr_d      = last_wr_q;
      rd_valid_d     = fifo_rd_en_q;
      cnt_dly_d      = count_q;
      chk_en_d       = 1'b1;

      if (do_wr) begin
         wr_gnt_d[wr_sel] = 1'b1;
         fifo_wr_en_d     = 1'b1;
         fifo_data_in_d   = wr_data[int'(wr_sel)*int'(FIFO_WIDTH) +: FIFO_WIDTH];
         count_d          = count_q + CNT_W'(1);
         last_wr_d        = wr_sel;
      end else if (do_rd) begin
         rd_gnt_d     = 1'b1;
         fifo_rd_en_d = 1'b1;
         count_d      = count_q - CNT_W'(1);
      end

      // cnt_dly lines up with the FIFO flags, which lag the command by one cycle
      flag_mismatch = ((cnt_dly_q == '0) != fifo_empty) ||
                      ((cnt_dly_q == CNT_W'(FIFO_DEPTH)) != fifo_full);
      err_d = err_q | (chk_en_q & flag_mismatch);
   end

   // State registers
   always_ff @(posedge clk) begin : state_p
      if (!rstN) begin
         wr_gnt_q       <= '0;
         rd_gnt_q       <= 1'b0;
         rd_valid_q     <= 1'b0;
         fifo_wr_en_q   <= 1'b0;
         fifo_rd_en_q   <= 1'b0;
         fifo_data_in_q <= '0;
         count_q        <= '0;
         cnt_dly_q      <= '0;
         err_q          <= 1'b0;
         rd_pri_q       <= 1'b0;
         last_wr_q      <= IDX_W'(NUM_WR - 1);
         chk_en_q       <= 1'b0;
      end else begin
         wr_gnt_q       <= wr_gnt_d;
         rd_gnt_q       <= rd_gnt_d;
         rd_valid_q     <= rd_valid_d;
         fifo_wr_en_q   <= fifo_wr_en_d;
         fifo_rd_en_q   <= fifo_rd_en_d;
         fifo_data_in_q <= fifo_data_in_d;
         count_q        <= count_d;
         cnt_dly_q      <= cnt_dly_d;
         err_q          <= err_d;
         rd_pri_q       <= rd_pri_d;
         last_wr_q      <= last_wr_d;
         chk_en_q       <= chk_en_d;
      end
   end

   assign wr_gnt       = wr_gnt_q;
   assign rd_gnt       = rd_gnt_q;
   assign rd_valid     = rd_valid_q;
   assign rd_data      = fifo_data_out;
   assign fifo_wr_en   = fifo_wr_en_q;
   assign fifo_rd_en   = fifo_rd_en_q;
   assign fifo_data_in = fifo_data_in_q;
   assign count        = count_q;
   assign err          = err_q;

   // Structural invariants of the issue logic
   a_no_wr_rd_together : assert property (@(posedge clk) disable iff (!rstN)
                                          !(fifo_wr_en_q && fifo_rd_en_q));
   a_count_bounded     : assert property (@(posedge clk) disable iff (!rstN)
                                          count_q <= CNT_W'(FIFO_DEPTH));

endmodule
